slider_debounce: RTL



---
 rtl/slider_debounce.sv | 79 +++++++
 1 files changed

// File: rtl/slider_debounce.sv
// Slide-switch conditioner: two-flop synchronizer plus an independent counter-based
// debouncer per bit, with registered one-cycle rise/fall/any_change strobes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   STABLE  | r_sync2[i] == r_out[i]; counter held at zero
//   PENDING | r_sync2[i] != r_out[i]; counter runs toward DEBOUNCE_CYCLES-1
module slider_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_change
);

   localparam logic [CNT_W-1:0] LP_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic             r_any;
   logic [CNT_W-1:0] r_cnt [WIDTH];

   logic [WIDTH-1:0] w_update;

   // A bit updates when it has mismatched long enough to reach terminal count.
   always_comb begin
      w_update = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_update[i] = (r_sync2[i] != r_out[i]) && (r_cnt[i] == LP_TC);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_out   <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_any   <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= in_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < WIDTH; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_sync2[i] == r_out[i]) begin
               r_cnt[i] <= '0;
            end else if (w_update[i]) begin
               r_out[i]  <= r_sync2[i];
               r_cnt[i]  <= '0;
               r_rise[i] <= r_sync2[i];
               r_fall[i] <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
         r_any <= |w_update;
      end
   end

   assign out_port   = r_out;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign any_change = r_any;

endmodule
